// File: rtl/clk_div_n.sv
// Runtime-programmable 50%-duty integer clock divider (N = 2..2^WIDTH-1, odd or even).
// Optional macro CLK_DIV_N_TICK_EN adds a one-cycle 'tick' pulse at the start of every running period.
module clk_div_n #(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic [WIDTH-1:0] cur_div,
    output logic             upd_pend,
    output logic             load_err
`ifdef CLK_DIV_N_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             upd_reg, upd_next;
    logic             err_reg, err_next;
    logic             run_reg, run_next;
    logic             up_reg, up_next;
    logic             dn_reg;
    logic             legal_load;
    logic             boundary;
    logic             apply_div;

    always_comb begin
        legal_load = div_load && (div_val >= TWO);
        boundary   = run_reg && (cnt_reg == div_reg - ONE);
        // A stopped divider restarts on the next edge, which is also a period boundary.
        apply_div  = boundary || (!run_reg && en);

        div_next  = div_reg;
        pend_next = pend_reg;
        upd_next  = upd_reg;
        if (apply_div) begin
            upd_next = 1'b0;
            if (legal_load) begin
                div_next  = div_val;
                pend_next = div_val;
            end else if (upd_reg) begin
                div_next = pend_reg;
            end
        end else if (legal_load) begin
            pend_next = div_val;
            upd_next  = 1'b1;
        end

        err_next = div_load && !legal_load;

        if (run_reg && !boundary) begin
            run_next = 1'b1;
            cnt_next = cnt_reg + ONE;
        end else begin
            run_next = en;
            cnt_next = '0;
        end

        // High for the first floor(N/2) counts of the period that starts with cnt_next.
        up_next = run_next && (cnt_next < (div_next >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            div_reg  <= DEF;
            pend_reg <= DEF;
            upd_reg  <= 1'b0;
            err_reg  <= 1'b0;
            run_reg  <= 1'b0;
            up_reg   <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            div_reg  <= div_next;
            pend_reg <= pend_next;
            upd_reg  <= upd_next;
            err_reg  <= err_next;
            run_reg  <= run_next;
            up_reg   <= up_next;
        end
    end

    // Half-cycle-delayed copy stretches odd-divisor pulses by half a source clock.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            dn_reg <= 1'b0;
        end else begin
            dn_reg <= up_reg;
        end
    end

    assign clk_out  = div_reg[0] ? (up_reg | dn_reg) : up_reg;
    assign cur_div  = div_reg;
    assign upd_pend = upd_reg;
    assign load_err = err_reg;

`ifdef CLK_DIV_N_TICK_EN
    logic tick_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= run_next && (cnt_next == '0);
        end
    end

    assign tick = tick_reg;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Scoreboard bench for clk_div_n: a period-level model predicts every clk_out pulse
// (rise time and width) and per-cycle status; monitors compare against the DUT.
module tb_clk_div_n;

    localparam int WIDTH = 8;
    localparam int DEF   = 15;
    localparam int HALF  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [WIDTH-1:0] div_val = '0;
    logic             div_load = 1'b0;
    logic             clk_out;
    logic [WIDTH-1:0] cur_div;
    logic             upd_pend;
    logic             load_err;
`ifdef CLK_DIV_N_TICK_EN
    logic             tick;
`endif

    clk_div_n #(.WIDTH(WIDTH), .DEF_DIV(DEF)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .cur_div  (cur_div),
        .upd_pend (upd_pend),
        .load_err (load_err)
`ifdef CLK_DIV_N_TICK_EN
        ,
        .tick     (tick)
`endif
    );

    always #HALF clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (period level) ----------------
    typedef struct { int t; int div; } pulse_t;
    typedef struct { int cdiv; bit upd; bit err; bit tck; } stat_t;
    pulse_t pq[$];
    stat_t  sq[$];

    int m_cyc = 0;
    int m_start = 0;
    int m_div = DEF;
    int m_pend = DEF;
    bit m_run = 0;
    bit m_upd = 0;

    always @(posedge clk or posedge rst) begin : model
        bit legal, bnd, start, err;
        if (rst) begin
            m_cyc = 0; m_start = 0; m_div = DEF; m_pend = DEF;
            m_run = 0; m_upd = 0;
            pq.delete();
            sq.delete();
        end else begin
            m_cyc++;
            legal = div_load && (int'(div_val) >= 2);
            err   = div_load && !legal;
            // The period started at edge m_start covers m_div cycles.
            bnd   = m_run && (m_cyc - m_start == m_div);
            if (bnd || (!m_run && en)) begin
                if (legal) begin m_div = int'(div_val); m_pend = int'(div_val); end
                else if (m_upd) m_div = m_pend;
                m_upd = 0;
            end else if (legal) begin
                m_pend = int'(div_val);
                m_upd = 1;
            end
            start = 0;
            if (!m_run || bnd) begin
                m_run = en;
                start = en;
            end
            if (start) begin
                m_start = m_cyc;
                pq.push_back('{int'($time), m_div});
            end
            sq.push_back('{m_div, m_upd, err, start});
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin : status_mon
        stat_t s;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            chk("cur_div", int'(cur_div), s.cdiv);
            chk("upd_pend", int'(upd_pend), int'(s.upd));
            chk("load_err", int'(load_err), int'(s.err));
`ifdef CLK_DIV_N_TICK_EN
            chk("tick", int'(tick), int'(s.tck));
`endif
        end
    end

    initial begin : pulse_mon
        pulse_t p;
        int t_rise;
        bit have;
        forever begin
            @(posedge clk_out);
            t_rise = int'($time);
            have = 0;
            if (!rst) begin
                if (pq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pulse_unexpected: clk_out rose at %0t, expected no pulse", $time);
                end else begin
                    p = pq.pop_front();
                    have = 1;
                    chk("pulse_rise_time", t_rise, p.t);
                end
            end
            @(negedge clk_out);
            if (!rst && have)
                chk("pulse_high_time", int'($time) - t_rise, p.div * HALF);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int v);
        $display("[TB] t=%0t load div_val=%0d (model div=%0d)", $time, v, m_div);
        div_val  = WIDTH'(v);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        bit ok = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (m_run && (m_cyc - m_start) == ph) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_phase: phase %0d not reached within 600 cycles", ph);
        end
    endtask

    initial begin
        int r;
        bit seen;
        cyc(3);
        rst = 1'b0;
        #1;
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_cur_div", int'(cur_div), DEF);
        chk("reset_upd_pend", int'(upd_pend), 0);
        chk("reset_load_err", int'(load_err), 0);

        en = 1'b1;
        cyc(40);

        // Load 4 mid-period of N=15: shadowed until the boundary.
        wait_phase(3);
        load(4);
        cyc(30);

        // Illegal loads.
        load(1);
        cyc(3);
        load(0);
        cyc(10);

        // Load exactly in the boundary cycle of an N=4 period.
        wait_phase(3);
        load(6);
        cyc(20);

        // Stop mid-period at N=5, then restart.
        load(5);
        cyc(14);
        wait_phase(1);
        en = 1'b0;
        cyc(20);
        en = 1'b1;
        cyc(20);

        // Randomized loads and enable toggling.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       load($urandom_range(0, 1));
            else if (r < 3)  load($urandom_range(2, 255));
            else if (r < 9)  load($urandom_range(2, 9));
            else if (r < 12) begin en = ~en; cyc(1); end
            else             cyc(1);
        end

        // Asynchronous reset while clk_out is high.
        en = 1'b1;
        load(7);
        seen = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (clk_out) begin seen = 1; break; end
        end
        chk("clk_out_seen_high", int'(seen), 1);
        #1 rst = 1'b1;
        #1 chk("async_reset_clk_out", int'(clk_out), 0);
        #1 rst = 1'b0;
        chk("post_reset_cur_div", int'(cur_div), DEF);
        chk("post_reset_upd_pend", int'(upd_pend), 0);

        cyc(50);
        en = 1'b0;
        seen = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!m_run) begin seen = 1; break; end
        end
        chk("stop_reached", int'(seen), 1);
        cyc(5);
        #1;
        chk("pulses_outstanding", pq.size(), 0);
        chk("final_clk_out", int'(clk_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
